// File: rtl/groovy_cmd_arbiter_if.sv
// Groovy command arbiter bus: decoder request flags and parameters, engine start/done
// handshakes, and arbiter status. The master modport is the arbiter's view.
interface groovy_cmd_arbiter_if;
    logic        cmd_switchres;
    logic        cmd_blit;
    logic        cmd_blit_lz4;
    logic        cmd_audio;
    logic [31:0] lz4_size;
    logic        lz4_AB;
    logic [15:0] audio_samples;
    logic        vga_vblank;

    logic        reset_switchres;
    logic        reset_blit;
    logic        reset_blit_lz4;
    logic        reset_audio;

    logic        sw_start;
    logic        blit_start;
    logic        lz4_start;
    logic        aud_start;
    logic [31:0] lz4_len;
    logic        lz4_buf;
    logic [15:0] aud_len;

    logic        sw_done;
    logic        blit_done;
    logic        lz4_done;
    logic        aud_done;

    logic        busy;
    logic [1:0]  grant;
    logic        err;

    modport master (
        input  cmd_switchres, cmd_blit, cmd_blit_lz4, cmd_audio,
        input  lz4_size, lz4_AB, audio_samples, vga_vblank,
        input  sw_done, blit_done, lz4_done, aud_done,
        output reset_switchres, reset_blit, reset_blit_lz4, reset_audio,
        output sw_start, blit_start, lz4_start, aud_start,
        output lz4_len, lz4_buf, aud_len,
        output busy, grant, err
    );

    modport slave (
        output cmd_switchres, cmd_blit, cmd_blit_lz4, cmd_audio,
        output lz4_size, lz4_AB, audio_samples, vga_vblank,
        output sw_done, blit_done, lz4_done, aud_done,
        input  reset_switchres, reset_blit, reset_blit_lz4, reset_audio,
        input  sw_start, blit_start, lz4_start, aud_start,
        input  lz4_len, lz4_buf, aud_len,
        input  busy, grant, err
    );
endinterface

// File: rtl/groovy_cmd_arbiter.sv
// Grants Groovy command flags to their engines one at a time over the shared DDR read path.
// Optional WAIT watchdog enabled by defining GROOVY_ARB_WATCHDOG_EN.
module groovy_cmd_arbiter #(
    parameter int unsigned       TO_W      = 24,
    parameter logic [TO_W-1:0]   TO_CYCLES = 24'd12_000_000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    groovy_cmd_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_GAP
    } state_e;

    // Encoding matches the externally visible grant code.
    typedef enum logic [1:0] {
        OWN_SW   = 2'd0,
        OWN_AUD  = 2'd1,
        OWN_LZ4  = 2'd2,
        OWN_BLIT = 2'd3
    } owner_e;

    state_e      state_q,   state_d;
    owner_e      grant_q,   grant_d;
    logic        zero_q,    zero_d;
    logic [31:0] lz4_len_q, lz4_len_d;
    logic        lz4_buf_q, lz4_buf_d;
    logic [15:0] aud_len_q, aud_len_d;

    logic [3:0]  ack_vec;
    logic [3:0]  start_vec;
    logic [3:0]  done_vec;

`ifdef GROOVY_ARB_WATCHDOG_EN
    logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [TO_W-1:0] wd_inc;
    logic            err_q,    err_d;

    assign wd_inc = wd_cnt_q + TO_W'(1);
`endif

    assign done_vec = {bus.blit_done, bus.lz4_done, bus.aud_done, bus.sw_done};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        grant_d   = grant_q;
        zero_d    = zero_q;
        lz4_len_d = lz4_len_q;
        lz4_buf_d = lz4_buf_q;
        aud_len_d = aud_len_q;
        ack_vec   = '0;
        start_vec = '0;
`ifdef GROOVY_ARB_WATCHDOG_EN
        wd_cnt_d  = wd_cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A switchres outside vblank simply loses this pass to lower requests.
                if (bus.cmd_switchres && bus.vga_vblank) begin
                    grant_d = OWN_SW;
                    zero_d  = 1'b0;
                    state_d = S_GRANT;
                end else if (bus.cmd_audio) begin
                    grant_d   = OWN_AUD;
                    zero_d    = (bus.audio_samples == 16'd0);
                    aud_len_d = bus.audio_samples;
                    state_d   = S_GRANT;
                end else if (bus.cmd_blit_lz4) begin
                    grant_d   = OWN_LZ4;
                    zero_d    = (bus.lz4_size == 32'd0);
                    lz4_len_d = bus.lz4_size;
                    lz4_buf_d = bus.lz4_AB;
                    state_d   = S_GRANT;
                end else if (bus.cmd_blit) begin
                    grant_d = OWN_BLIT;
                    zero_d  = 1'b0;
                    state_d = S_GRANT;
                end
            end

            S_GRANT: begin
                ack_vec[grant_q]   = 1'b1;
                start_vec[grant_q] = !zero_q;
                state_d            = zero_q ? S_GAP : S_WAIT;
`ifdef GROOVY_ARB_WATCHDOG_EN
                wd_cnt_d           = '0;
`endif
            end

            S_WAIT: begin
                if (done_vec[grant_q]) begin
                    state_d = S_GAP;
`ifdef GROOVY_ARB_WATCHDOG_EN
                end else begin
                    wd_cnt_d = wd_inc;
                    if (wd_inc == TO_CYCLES) begin
                        err_d   = 1'b1;
                        state_d = S_GAP;
                    end
`endif
                end
            end

            // One turnaround cycle lets the decoder drop the acknowledged flag first.
            S_GAP: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= OWN_SW;
            zero_q    <= 1'b0;
            lz4_len_q <= '0;
            lz4_buf_q <= 1'b0;
            aud_len_q <= '0;
`ifdef GROOVY_ARB_WATCHDOG_EN
            wd_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            zero_q    <= zero_d;
            lz4_len_q <= lz4_len_d;
            lz4_buf_q <= lz4_buf_d;
            aud_len_q <= aud_len_d;
`ifdef GROOVY_ARB_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign {bus.reset_blit, bus.reset_blit_lz4, bus.reset_audio, bus.reset_switchres} = ack_vec;
    assign {bus.blit_start, bus.lz4_start, bus.aud_start, bus.sw_start}               = start_vec;

    assign bus.lz4_len = lz4_len_q;
    assign bus.lz4_buf = lz4_buf_q;
    assign bus.aud_len = aud_len_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.grant   = grant_q;

`ifdef GROOVY_ARB_WATCHDOG_EN
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_groovy_cmd_arbiter.sv
// Directed bench for groovy_cmd_arbiter: a scoreboard of expected grants is filled as requests
// are raised and drained by a monitor on every acknowledge pulse.
module tb_groovy_cmd_arbiter;

    localparam logic [1:0] OWN_SW   = 2'd0;
    localparam logic [1:0] OWN_AUD  = 2'd1;
    localparam logic [1:0] OWN_LZ4  = 2'd2;
    localparam logic [1:0] OWN_BLIT = 2'd3;

    typedef struct {
        logic [1:0]  owner;
        logic        started;
        logic [31:0] len;
        logic        lbuf;
    } exp_t;

    logic clk_sys;
    logic reset;
    logic auto_clear;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    groovy_cmd_arbiter_if bus ();

    groovy_cmd_arbiter #(
        .TO_W      (24),
        .TO_CYCLES (24'd100)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] owner, input logic started,
                            input logic [31:0] len, input logic lbuf);
        exp_t e;
        e.owner   = owner;
        e.started = started;
        e.len     = len;
        e.lbuf    = lbuf;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] ack_bits();
        return {bus.reset_blit, bus.reset_blit_lz4, bus.reset_audio, bus.reset_switchres};
    endfunction

    function automatic logic [3:0] start_bits();
        return {bus.blit_start, bus.lz4_start, bus.aud_start, bus.sw_start};
    endfunction

    // Scoreboard monitor: each acknowledge pulse must match the oldest expected grant.
    initial begin
        exp_t e;
        logic [3:0] ack;
        forever begin
            @(negedge clk_sys);
            ack = ack_bits();
            if (ack != 4'b0) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ack", 32'(ack), 32'(4'b0001 << e.owner));
                    check("sb_start", 32'(start_bits()), e.started ? 32'(4'b0001 << e.owner) : 32'd0);
                    check("sb_grant", 32'(bus.grant), 32'(e.owner));
                    if (e.owner == OWN_AUD) check("sb_aud_len", 32'(bus.aud_len), e.len);
                    if (e.owner == OWN_LZ4) begin
                        check("sb_lz4_len", bus.lz4_len, e.len);
                        check("sb_lz4_buf", 32'(bus.lz4_buf), 32'(e.lbuf));
                    end
                end
            end
        end
    end

    // Decoder model: an acknowledged flag drops one edge after its reset_* pulse.
    initial begin
        logic [3:0] a;
        forever begin
            @(negedge clk_sys);
            a = ack_bits();
            if (auto_clear && a != 4'b0) begin
                @(posedge clk_sys);
                #1;
                if (a[0]) bus.cmd_switchres = 1'b0;
                if (a[1]) bus.cmd_audio     = 1'b0;
                if (a[2]) bus.cmd_blit_lz4  = 1'b0;
                if (a[3]) bus.cmd_blit      = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        auto_clear = 1'b1;
        reset      = 1'b1;
        bus.cmd_switchres = 1'b0;
        bus.cmd_blit      = 1'b0;
        bus.cmd_blit_lz4  = 1'b0;
        bus.cmd_audio     = 1'b0;
        bus.lz4_size      = 32'd0;
        bus.lz4_AB        = 1'b0;
        bus.audio_samples = 16'd0;
        bus.vga_vblank    = 1'b0;
        bus.sw_done       = 1'b0;
        bus.blit_done     = 1'b0;
        bus.lz4_done      = 1'b0;
        bus.aud_done      = 1'b0;

        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_grant",   32'(bus.grant), 32'd0);
        check("rst_err",     32'(bus.err), 32'd0);
        check("rst_lz4_len", bus.lz4_len, 32'd0);
        check("rst_lz4_buf", 32'(bus.lz4_buf), 32'd0);
        check("rst_aud_len", 32'(bus.aud_len), 32'd0);
        check("rst_pulses",  32'({ack_bits(), start_bits()}), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Single blit, including done during GRANT and stray dones from other engines.
        bus.cmd_blit = 1'b1;
        push_exp(OWN_BLIT, 1'b1, 32'd0, 1'b0);
        tick();
        check("blit_start_hi", 32'(bus.blit_start), 32'd1);
        check("blit_ack_hi",   32'(bus.reset_blit), 32'd1);
        check("blit_grant",    32'(bus.grant), 32'(OWN_BLIT));
        check("blit_busy",     32'(bus.busy), 32'd1);
        bus.blit_done = 1'b1;
        tick();
        bus.blit_done = 1'b0;
        check("blit_start_once", 32'(bus.blit_start), 32'd0);
        check("blit_ack_once",   32'(bus.reset_blit), 32'd0);
        bus.aud_done = 1'b1;
        tick();
        bus.aud_done = 1'b0;
        bus.lz4_done = 1'b1;
        tick();
        bus.lz4_done = 1'b0;
        tick();
        check("stray_done_busy",  32'(bus.busy), 32'd1);
        check("stray_done_grant", 32'(bus.grant), 32'(OWN_BLIT));
        bus.blit_done = 1'b1;
        tick();
        bus.blit_done = 1'b0;
        check("blit_gap_busy", 32'(bus.busy), 32'd1);
        tick();
        check("blit_idle_busy", 32'(bus.busy), 32'd0);

        // Three simultaneous requests served audio, lz4, blit, 3 cycles after each done.
        bus.lz4_size      = 32'h0000_1234;
        bus.lz4_AB        = 1'b1;
        bus.audio_samples = 16'h0200;
        bus.cmd_blit      = 1'b1;
        bus.cmd_blit_lz4  = 1'b1;
        bus.cmd_audio     = 1'b1;
        push_exp(OWN_AUD,  1'b1, 32'h0000_0200, 1'b0);
        push_exp(OWN_LZ4,  1'b1, 32'h0000_1234, 1'b1);
        push_exp(OWN_BLIT, 1'b1, 32'd0,         1'b0);
        tick();
        check("multi_aud_start", 32'(bus.aud_start), 32'd1);
        tick();
        bus.aud_done = 1'b1;
        tick();
        bus.aud_done = 1'b0;
        tick();
        check("multi_gap_idle", 32'(bus.busy), 32'd0);
        tick();
        check("multi_lz4_start", 32'(bus.lz4_start), 32'd1);
        bus.lz4_size = 32'h0000_DEAD;
        tick();
        check("lz4_len_hold", bus.lz4_len, 32'h0000_1234);
        check("aud_len_hold", 32'(bus.aud_len), 32'h0000_0200);
        bus.lz4_done = 1'b1;
        tick();
        bus.lz4_done = 1'b0;
        tick();
        tick();
        check("multi_blit_start", 32'(bus.blit_start), 32'd1);
        tick();
        bus.blit_done = 1'b1;
        tick();
        bus.blit_done = 1'b0;
        tick();
        check("multi_end_idle", 32'(bus.busy), 32'd0);

        // Switchres outside vblank yields to blit, then wins as soon as vblank arrives.
        bus.vga_vblank    = 1'b0;
        bus.cmd_switchres = 1'b1;
        bus.cmd_blit      = 1'b1;
        push_exp(OWN_BLIT, 1'b1, 32'd0, 1'b0);
        push_exp(OWN_SW,   1'b1, 32'd0, 1'b0);
        tick();
        check("sw_blocked_grant", 32'(bus.grant), 32'(OWN_BLIT));
        tick();
        bus.vga_vblank = 1'b1;
        tick();
        tick();
        check("sw_wait_grant", 32'(bus.grant), 32'(OWN_BLIT));
        bus.blit_done = 1'b1;
        tick();
        bus.blit_done = 1'b0;
        tick();
        tick();
        check("sw_start", 32'(bus.sw_start), 32'd1);
        check("sw_grant", 32'(bus.grant), 32'(OWN_SW));
        tick();
        bus.sw_done = 1'b1;
        tick();
        bus.sw_done = 1'b0;
        tick();
        bus.vga_vblank = 1'b0;
        check("sw_end_idle", 32'(bus.busy), 32'd0);

        // Zero-length lz4: acknowledge only, back in IDLE two cycles later.
        bus.lz4_size     = 32'd0;
        bus.lz4_AB       = 1'b0;
        bus.cmd_blit_lz4 = 1'b1;
        push_exp(OWN_LZ4, 1'b0, 32'd0, 1'b0);
        tick();
        check("zero_ack",   32'(bus.reset_blit_lz4), 32'd1);
        check("zero_start", 32'(bus.lz4_start), 32'd0);
        tick();
        check("zero_gap_busy", 32'(bus.busy), 32'd1);
        tick();
        check("zero_idle_busy", 32'(bus.busy), 32'd0);

        // Reset during lz4 WAIT with the flag left high: re-granted with a fresh size.
        auto_clear       = 1'b0;
        bus.lz4_size     = 32'h0000_55AA;
        bus.lz4_AB       = 1'b0;
        bus.cmd_blit_lz4 = 1'b1;
        push_exp(OWN_LZ4, 1'b1, 32'h0000_55AA, 1'b0);
        tick();
        tick();
        check("rst_mid_len_before", bus.lz4_len, 32'h0000_55AA);
        #3;
        reset = 1'b1;
        #1;
        check("async_busy",    32'(bus.busy), 32'd0);
        check("async_grant",   32'(bus.grant), 32'd0);
        check("async_lz4_len", bus.lz4_len, 32'd0);
        check("async_aud_len", 32'(bus.aud_len), 32'd0);
        check("async_pulses",  32'({ack_bits(), start_bits()}), 32'd0);
        bus.lz4_size = 32'h0000_0777;
        bus.lz4_AB   = 1'b1;
        push_exp(OWN_LZ4, 1'b1, 32'h0000_0777, 1'b1);
        auto_clear = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("regrant_start", 32'(bus.lz4_start), 32'd1);
        check("regrant_len",   bus.lz4_len, 32'h0000_0777);
        tick();
        bus.lz4_done = 1'b1;
        tick();
        bus.lz4_done = 1'b0;
        tick();
        check("regrant_idle", 32'(bus.busy), 32'd0);

        // Withheld blit_done: watchdog abort when enabled, unbounded WAIT otherwise.
        bus.cmd_blit = 1'b1;
        push_exp(OWN_BLIT, 1'b1, 32'd0, 1'b0);
        tick();
`ifdef GROOVY_ARB_WATCHDOG_EN
        repeat (100) tick();
        check("wd_err_not_yet", 32'(bus.err), 32'd0);
        check("wd_still_wait",  32'(bus.busy), 32'd1);
        tick();
        check("wd_err_set",  32'(bus.err), 32'd1);
        tick();
        check("wd_idle",     32'(bus.busy), 32'd0);
        repeat (5) tick();
        check("wd_err_sticky", 32'(bus.err), 32'd1);
        check("wd_no_restart", 32'(bus.busy), 32'd0);
`else
        repeat (150) tick();
        check("nowd_err",  32'(bus.err), 32'd0);
        check("nowd_busy", 32'(bus.busy), 32'd1);
        bus.blit_done = 1'b1;
        tick();
        bus.blit_done = 1'b0;
        tick();
        check("nowd_idle", 32'(bus.busy), 32'd0);
`endif
        reset = 1'b1;
        tick();
        check("final_err_clear", 32'(bus.err), 32'd0);
        reset = 1'b0;
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/groovy_cmd_arbiter.md
# groovy_cmd_arbiter

- Sequences the Groovy command flags latched by the HPS command decoder (switchres, blit, LZ4 blit, audio) onto their datapath engines.
- Only one engine owns the shared DDR read path at a time.
- Grants engines in priority order, issues one-cycle start pulses with captured parameters, and acknowledges each flag back to the decoder through its `reset_*` input.
- Tracks engine completion, with an optional watchdog.

## Interface
Parameters:
- `TO_W`, default 24: watchdog counter width.
- `TO_CYCLES`, default 24'd12_000_000: cycles allowed in WAIT before abort.

Ports:
- `clk_sys`  in  1  system clock; the block's only clock.
- `reset`  in  1  reset, asynchronous and active-high.
- `cmd_switchres`, `cmd_blit`, `cmd_blit_lz4`, `cmd_audio`  in  1 each  level request flags; each stays high until acknowledged.
- `lz4_size`  in  32  compressed byte count.
- `lz4_AB`  in  1  LZ4 buffer select.
- `audio_samples`  in  16  audio sample count.
- `vga_vblank`  in  1  vertical blank.
- `reset_switchres`, `reset_blit`, `reset_blit_lz4`, `reset_audio`  out  1 each  one-cycle flag-clear pulses.
- `sw_start`, `blit_start`, `lz4_start`, `aud_start`  out  1 each  one-cycle engine start pulses.
- `lz4_len`  out  32  value of `lz4_size` captured at grant.
- `lz4_buf`  out  1  value of `lz4_AB` captured at grant.
- `aud_len`  out  16  value of `audio_samples` captured at grant.
- `sw_done`, `blit_done`, `lz4_done`, `aud_done`  in  1 each  engine completion pulses.
- `busy`  out  1  high in GRANT, WAIT and GAP.
- `grant`  out  2  current or last owner: 0 switchres, 1 audio, 2 lz4, 3 blit.
- `err`  out  1  sticky watchdog abort flag.

## Operation
- FSM states: IDLE, GRANT, WAIT, GAP.
- IDLE: evaluate requests in fixed priority.
  - `cmd_switchres` wins, but only while `vga_vblank`=1.
  - Then `cmd_audio`, then `cmd_blit_lz4`, then `cmd_blit`.
  - A winner sets `grant`, captures its parameters, and moves to GRANT.
  - A pending switchres outside vblank does not block lower requests.
- GRANT (one cycle): pulse the winner's `*_start` and matching `reset_*` together, then go to WAIT.
- Zero-length shortcut: `lz4_size`=0 or `audio_samples`=0 at grant.
  - Pulse `reset_*` only, with no start pulse.
  - Go directly to GAP.
- WAIT: exit on the `*_done` of the granted engine only.
  - `*_done` from non-granted engines is ignored in all states.
  - Done detected moves to GAP.
- GAP (one cycle): turnaround to IDLE. It guarantees that an acknowledged flag, which the decoder clears one edge after `reset_*`, is never resampled.
- Parameters `lz4_len`, `lz4_buf` and `aud_len` hold from grant until the next grant of the same engine.
- Reset mid-operation: FSM goes to IDLE, with no pulses emitted.
  - Decoder flags are unaffected, so un-acknowledged requests are re-granted after reset.
  - An engine already started must be reset by the same `reset`.

## Timing
- Reset values: all pulses 0, `busy`=0, `grant`=0, `err`=0, `lz4_len`=0, `lz4_buf`=0, `aud_len`=0.
- Request sampled in IDLE at edge N: GRANT outputs are high during cycle N+1 (exactly one cycle).
- `busy` rises at N+1.
- Done sampled at edge M in WAIT: GAP at M+1, IDLE at M+2.
  - Earliest next start is M+3.
- `*_done` coincident with its own start cycle (GRANT) is ignored. Engines must assert done at least one cycle after start.
- Done and a new request in the same cycle: the request waits for IDLE.
- Multiple simultaneous requests: exactly one is granted per pass. The others remain pending and are served in priority order.
- Starvation: blit can starve under continuous audio. This is accepted; audio is bounded by the frame rate.

## Configuration
- `GROOVY_ARB_WATCHDOG_EN` defined:
  - An unsigned `TO_W`-bit counter clears in GRANT and increments in WAIT.
  - When it reaches `TO_CYCLES` with no done, set `err`=1 (sticky until `reset`) and go to GAP.
  - The engine is not re-started.
- Macro undefined: no counter, WAIT is unbounded, and `err` is tied to 0.

## Test plan
- `cmd_blit`=1 at edge 10 → `blit_start` and `reset_blit` high in cycle 11 only, `grant`=3, `busy`=1; `blit_done` at 20 → `busy`=0 from cycle 22.
- `cmd_blit`, `cmd_blit_lz4` and `cmd_audio` all high with `lz4_size`=0x1234 and `audio_samples`=0x0200:
  - grant order is audio (`aud_len`=0x0200), then lz4 (`lz4_len`=0x1234), then blit;
  - each grant starts 3 cycles after the previous done.
- `cmd_switchres`=1 and `cmd_blit`=1 with `vga_vblank`=0 → blit granted first; raise `vga_vblank` during WAIT → switchres granted immediately after blit GAP.
- `cmd_blit_lz4` with `lz4_size`=0 → `reset_blit_lz4` pulse, no `lz4_start`, back in IDLE 2 cycles later; also check that a stray `aud_done` during a blit WAIT is ignored.
- Assert `reset` during lz4 WAIT → all outputs go to their reset values asynchronously; flag still high → re-granted after release with newly captured `lz4_size`.
- With `GROOVY_ARB_WATCHDOG_EN` and `TO_CYCLES`=100, withhold `blit_done` → `err`=1 after 100 WAIT cycles, FSM returns to IDLE; without the macro, `err` stays 0 and `busy` stays 1.
